lifo_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 8-bit linear stack. Two requesters issue push or pop operations. The block arbitrates between them round-robin and drives the stack's write and read strobes for exactly one clock per operation. It returns pop data or a rejection to the winning requester. Occupancy is tracked internally, so over- and underflow are refused before they reach the stack.

---
 rtl/lifo_arbiter.sv | 115 +++++++++++
 tb/tb_lifo_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
// Round-robin two-port arbiter/sequencer for a shared linear stack; refuses over/underflow.
// Optional rejected-operation counter (err_cnt) enabled by defining LIFO_ARB_ERR_CNT_EN.
module lifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7,
  parameter int LW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_wn,
  output logic             stk_rn,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [LW-1:0]    level
`ifdef LIFO_ARB_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state, state_nxt;
  logic             id_q, op_q, ok_q, last_q;
  logic [WIDTH-1:0] wd_q;
  logic             any_req, win, win_op, win_ok;
  logic [WIDTH-1:0] win_wd;

  // last_q names the port granted most recently; on a tie the other port wins
  always_comb begin
    any_req = req0 | req1;
    win     = (req0 & req1) ? ~last_q : req1;
    win_op  = win ? op1 : op0;
    win_wd  = win ? wdata1 : wdata0;
    win_ok  = win_op ? (level < LW'(DEPTH)) : (level != '0);
  end

  always_comb begin
    state_nxt = state;
    stk_wn    = 1'b0;
    stk_rn    = 1'b0;
    stk_din   = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = DONE;
        stk_wn    = ok_q & op_q;
        stk_rn    = ok_q & ~op_q;
        if (ok_q && op_q) stk_din = wd_q;
      end
      DONE: begin
        state_nxt = IDLE;
        ack0      = ~id_q;
        ack1      = id_q;
        err       = ~ok_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      id_q   <= 1'b0;
      op_q   <= 1'b0;
      ok_q   <= 1'b0;
      last_q <= 1'b1;
      wd_q   <= '0;
      rdata  <= '0;
      level  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        id_q   <= win;
        op_q   <= win_op;
        ok_q   <= win_ok;
        wd_q   <= win_wd;
        last_q <= win;
      end
      // stack has already acted on the falling edge inside ISSUE
      if (state == ISSUE && ok_q) begin
        if (op_q) begin
          level <= level + 1'b1;
        end else begin
          level <= level - 1'b1;
          rdata <= stk_dout;
        end
      end
    end
  end

`ifdef LIFO_ARB_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (state == DONE && !ok_q && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter: directed ops queue expected acks/strobes,
// negedge monitors pop and compare. A small behavioural stack supplies stk_dout.
module tb_lifo_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, err, stk_wn, stk_rn;
  logic [7:0] rdata, stk_din;
  logic [7:0] stk_dout = '0;
  logic [3:0] level;
`ifdef LIFO_ARB_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clock = ~clock;

  lifo_arbiter #(.WIDTH(8), .DEPTH(7), .LW(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .stk_wn(stk_wn), .stk_rn(stk_rn), .stk_din(stk_din), .stk_dout(stk_dout),
    .level(level)
`ifdef LIFO_ARB_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  int checks = 0, failures = 0, cyc = 0;
  bit cont_mode = 0;
  int last_ack_cyc = -1;

  typedef struct {int port; logic e; logic chk_rd; logic [7:0] rd; logic [3:0] lvl;} ack_t;
  typedef struct {logic wr; logic [7:0] din;} stb_t;
  ack_t ackq[$];
  stb_t stbq[$];

  always @(posedge clock) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(string name, string detail);
    checks++;
    failures++;
    $display("FAIL %s %s t=%0t", name, detail, $time);
  endtask

  task automatic exp_ack(int p, logic e, logic c, logic [7:0] rd, logic [3:0] l);
    ack_t a;
    a = '{p, e, c, rd, l};
    ackq.push_back(a);
  endtask

  task automatic exp_stb(logic wr, logic [7:0] d);
    stb_t s;
    s = '{wr, d};
    stbq.push_back(s);
  endtask

  // behavioural stack: acts on the falling edge, reset with the arbiter
  logic [7:0] mem [0:7];
  int sp = 0;
  always @(negedge clock) begin
    if (!reset) sp = 0;
    else begin
      if (stk_wn && sp < 8) begin mem[sp] = stk_din; sp++; end
      if (stk_rn && sp > 0) begin sp--; stk_dout = mem[sp]; end
    end
  end

  always @(negedge clock) begin : monitor
    ack_t a;
    stb_t s;
    int p;
    if (reset) begin
      if (stk_wn && stk_rn) note_fail("strobe_overlap", "stk_wn and stk_rn both high");
      if (stk_wn || stk_rn) begin
        if (stbq.size() == 0) note_fail("unexpected_strobe", $sformatf("wn=%0b rn=%0b", stk_wn, stk_rn));
        else begin
          s = stbq.pop_front();
          check("strobe_kind", {31'd0, stk_wn}, {31'd0, s.wr});
          if (s.wr) check("stk_din", {24'd0, stk_din}, {24'd0, s.din});
        end
      end
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        if (ack0 && ack1) note_fail("ack_both", "ack0 and ack1 together");
        if ((ack0 && !req0) || (ack1 && !req1)) note_fail("ack_no_req", $sformatf("port %0d", p));
        if (cont_mode) begin
          if (last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 3);
          last_ack_cyc = cyc;
        end
        if (ackq.size() == 0) note_fail("unexpected_ack", $sformatf("port %0d", p));
        else begin
          a = ackq.pop_front();
          check("ack_port", p, a.port);
          check("err", {31'd0, err}, {31'd0, a.e});
          check("level", {28'd0, level}, {28'd0, a.lvl});
          if (a.chk_rd) check("rdata", {24'd0, rdata}, {24'd0, a.rd});
        end
      end
    end
  end

  task automatic drive(int p, logic op, logic [7:0] wd);
    bit got = 0;
    if (p == 0) begin op0 = op; wdata0 = wd; req0 = 1'b1; end
    else        begin op1 = op; wdata1 = wd; req1 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin got = 1; break; end
    end
    if (!got) note_fail("ack_timeout", $sformatf("port %0d", p));
    @(posedge clock);
    #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  logic [7:0] pop_d [0:6] = '{8'h42, 8'h41, 8'h40, 8'h33, 8'h32, 8'h31, 8'h30};

  initial begin
    #2;
    check("rst_ack0", {31'd0, ack0}, 0);
    check("rst_ack1", {31'd0, ack1}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    check("rst_stk_wn", {31'd0, stk_wn}, 0);
    check("rst_stk_rn", {31'd0, stk_rn}, 0);
    check("rst_stk_din", {24'd0, stk_din}, 0);
    check("rst_level", {28'd0, level}, 0);
`ifdef LIFO_ARB_ERR_CNT_EN
    check("rst_err_cnt", {24'd0, err_cnt}, 0);
`endif
    @(posedge clock); #1 reset = 1'b1;

    // single push
    exp_stb(1, 8'hA5); exp_ack(0, 0, 1, 8'h00, 1);
    drive(0, 1, 8'hA5);

    // push then pop
    do_reset();
    exp_stb(1, 8'h11); exp_ack(0, 0, 0, 0, 1); drive(0, 1, 8'h11);
    exp_stb(1, 8'h22); exp_ack(1, 0, 0, 0, 2); drive(1, 1, 8'h22);
    exp_stb(0, 0);     exp_ack(0, 0, 1, 8'h22, 1); drive(0, 0, 0);

    // contention: port 0 wins the first tie after reset, then alternate
    do_reset();
    exp_stb(1, 8'h30); exp_ack(0, 0, 1, 0, 1);
    exp_stb(1, 8'h31); exp_ack(1, 0, 1, 0, 2);
    exp_stb(1, 8'h32); exp_ack(0, 0, 1, 0, 3);
    exp_stb(1, 8'h33); exp_ack(1, 0, 1, 0, 4);
    cont_mode = 1; last_ack_cyc = -1;
    fork
      begin drive(0, 1, 8'h30); drive(0, 1, 8'h32); end
      begin drive(1, 1, 8'h31); drive(1, 1, 8'h33); end
    join
    cont_mode = 0;

    // fill to DEPTH, then overflow attempts
    exp_stb(1, 8'h40); exp_ack(1, 0, 0, 0, 5); drive(1, 1, 8'h40);
    exp_stb(1, 8'h41); exp_ack(1, 0, 0, 0, 6); drive(1, 1, 8'h41);
    exp_stb(1, 8'h42); exp_ack(1, 0, 0, 0, 7); drive(1, 1, 8'h42);
    exp_ack(0, 1, 1, 8'h00, 7); drive(0, 1, 8'h33);
    exp_ack(1, 1, 1, 8'h00, 7);
    exp_ack(0, 1, 1, 8'h00, 7);
    fork
      drive(0, 1, 8'h50);
      drive(1, 1, 8'h51);
    join

    // drain, then underflow
    for (int i = 0; i < 7; i++) begin
      exp_stb(0, 0);
      exp_ack(i % 2, 0, 1, pop_d[i], 4'(6 - i));
      drive(i % 2, 0, 0);
    end
    exp_ack(0, 1, 1, 8'h30, 0); drive(0, 0, 0);
`ifdef LIFO_ARB_ERR_CNT_EN
    check("err_cnt", {24'd0, err_cnt}, 4);
`endif

    // reset dropped during ISSUE of an accepted pop
    exp_stb(1, 8'h77); exp_ack(0, 0, 0, 0, 1); drive(0, 1, 8'h77);
    exp_stb(0, 0);
    op1 = 1'b0; req1 = 1'b1;
    begin : wait_rn
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (stk_rn) begin seen = 1; break; end
      end
      if (!seen) note_fail("rn_timeout", "stk_rn never rose");
    end
    #1 reset = 1'b0;
    #1;
    check("midrst_stk_rn", {31'd0, stk_rn}, 0);
    check("midrst_level", {28'd0, level}, 0);
    check("midrst_ack1", {31'd0, ack1}, 0);
    @(posedge clock); #1 req1 = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (4) @(posedge clock);
    exp_stb(1, 8'h88); exp_ack(1, 0, 1, 8'h00, 1); drive(1, 1, 8'h88);
    exp_stb(0, 0);     exp_ack(0, 0, 1, 8'h88, 0); drive(0, 0, 0);

    repeat (4) @(posedge clock);
    check("ackq_empty", ackq.size(), 0);
    check("stbq_empty", stbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
